// File: rtl/spart_driver_if.sv
// SPART register bus: chip select, direction, address and the shared 8-bit data bus.
// Each side drives the bus through its own enable; the resolved value is databus.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] db_out;
    logic       db_oe;
    logic [7:0] sl_out;
    logic       sl_oe;
    wire  [7:0] databus;

    // Master data wins only when it is enabled; an undriven bus floats.
    assign databus = db_oe ? db_out : (sl_oe ? sl_out : 8'hzz);

    modport master (
        output iocs, iorw, ioaddr, db_out, db_oe,
        input  databus
    );

    modport slave (
        input  iocs, iorw, ioaddr, databus,
        output sl_out, sl_oe
    );
endinterface

// File: rtl/spart_driver.sv
// Bus master for the SPART: programs the baud divisor, then echoes every received byte.
// Handshake: a read is sampled at the edge ending its state; a write is latched by the SPART at the edge ending its one-cycle state.
module spart_driver #(
    parameter logic [15:0] DIV0 = 16'h028A,
    parameter logic [15:0] DIV1 = 16'h0145,
    parameter logic [15:0] DIV2 = 16'h00A2,
    parameter logic [15:0] DIV3 = 16'h0050
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            br_cfg,
    spart_driver_if.master        bus,
    output logic                  cfg_done,
    output logic                  echo_valid,
    output logic [7:0]            echo_byte,
    output logic [15:0]           rx_count,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_INIT_LOW  = 3'd1,
        S_INIT_HIGH = 3'd2,
        S_POLL      = 3'd3,
        S_READ_RX   = 3'd4,
        S_WAIT_TBR  = 3'd5,
        S_WRITE_TX  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  br_cfg_q, br_cfg_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        cfg_done_q, cfg_done_d;
    logic [7:0]  echo_byte_q, echo_byte_d;
    logic [15:0] rx_count_q, rx_count_d;
    logic [15:0] div_sel;
    logic        iocs, iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  db_out;

    always_comb begin
        case (br_cfg_q)
            2'b00:   div_sel = DIV0;
            2'b01:   div_sel = DIV1;
            2'b10:   div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        br_cfg_d    = br_cfg_q;
        rx_byte_d   = rx_byte_q;
        cfg_done_d  = cfg_done_q;
        echo_byte_d = echo_byte_q;
        rx_count_d  = rx_count_q;
        iocs        = 1'b1;
        iorw        = 1'b1;
        ioaddr      = 2'b01;
        db_out      = 8'h00;
        case (state_q)
            S_RESET: begin
                iocs     = 1'b0;
                br_cfg_d = br_cfg;
                state_d  = S_INIT_LOW;
            end
            S_INIT_LOW: begin
                iorw    = 1'b0;
                ioaddr  = 2'b10;
                db_out  = div_sel[7:0];
                state_d = S_INIT_HIGH;
            end
            S_INIT_HIGH: begin
                iorw       = 1'b0;
                ioaddr     = 2'b11;
                db_out     = div_sel[15:8];
                cfg_done_d = 1'b1;
                state_d    = S_POLL;
            end
            S_POLL: begin
                // A baud change outranks a pending receive.
                if (br_cfg != br_cfg_q) begin
                    cfg_done_d = 1'b0;
                    br_cfg_d   = br_cfg;
                    state_d    = S_INIT_LOW;
                end else if (bus.databus[0]) begin
                    state_d = S_READ_RX;
                end
            end
            S_READ_RX: begin
                ioaddr     = 2'b00;
                rx_byte_d  = bus.databus;
                rx_count_d = rx_count_q + 16'd1;
                state_d    = S_WAIT_TBR;
            end
            S_WAIT_TBR: begin
                if (bus.databus[1]) state_d = S_WRITE_TX;
            end
            S_WRITE_TX: begin
                iorw        = 1'b0;
                ioaddr      = 2'b00;
                db_out      = rx_byte_q;
                echo_byte_d = rx_byte_q;
                state_d     = S_POLL;
            end
            default: begin
                iocs    = 1'b0;
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            br_cfg_q    <= 2'b00;
            rx_byte_q   <= 8'h00;
            cfg_done_q  <= 1'b0;
            echo_byte_q <= 8'h00;
            rx_count_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            br_cfg_q    <= br_cfg_d;
            rx_byte_q   <= rx_byte_d;
            cfg_done_q  <= cfg_done_d;
            echo_byte_q <= echo_byte_d;
            rx_count_q  <= rx_count_d;
        end
    end

    assign bus.iocs   = iocs;
    assign bus.iorw   = iorw;
    assign bus.ioaddr = ioaddr;
    assign bus.db_out = db_out;
    assign bus.db_oe  = iocs & ~iorw;

    assign cfg_done   = cfg_done_q;
    assign echo_valid = (state_q == S_WRITE_TX);
    assign echo_byte  = echo_byte_q;
    assign rx_count   = rx_count_q;
    assign dbg_state  = state_q;

endmodule
